// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the pipeline memory-access stage.
// Keeps the state encoding and the wait-counter width in one place.
package mem_stage_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int RD_W_DEF     = 3;
    localparam int MAX_WAIT_DEF = 15;

    // Wide enough for any MAX_WAIT up to 16 (counter tops out at MAX_WAIT-1).
    localparam int WAIT_CNT_W   = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

endpackage

// File: rtl/mem_stage_mem_wb.sv
// MEM/WB pipeline register: write-back enable, value and destination.
// A bubble clears only the write enable; data and destination hold.
module mem_wb_reg
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = RD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bubble,
    input  logic              reg_wr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [RD_W-1:0]   rd,
    output logic              reg_wr_q,
    output logic [DATA_W-1:0] wb_data_q,
    output logic [RD_W-1:0]   rd_q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_wr_q  <= 1'b0;
            wb_data_q <= '0;
            rd_q      <= '0;
        end else begin
            reg_wr_q <= bubble ? 1'b0 : reg_wr;
            if (!bubble) begin
                wb_data_q <= wb_data;
                rd_q      <= rd;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives data memory over req/ack, stalls upstream
// while an access is outstanding, aborts on timeout, feeds MEM/WB.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no access in flight; ALU ops retire, memory ops launch
//   ST_ACCESS | request on dmem, waiting for ack or for the wait limit
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RD_W     = RD_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regWr_IN,
    input  logic              memWr_IN,
    input  logic              memRd_IN,
    input  logic [DATA_W-1:0] aluRes_IN,
    input  logic [DATA_W-1:0] memWrData_IN,
    input  logic [RD_W-1:0]   rd_IN,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall,
    output logic              regWr_OUT,
    output logic [DATA_W-1:0] wbData_OUT,
    output logic [RD_W-1:0]   rd_OUT,
    output logic              memErr
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

    state_t                  state, state_nxt;
    logic [WAIT_CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic                    req_nxt, we_nxt, err_nxt;
    logic [DATA_W-1:0]       addr_nxt, wdata_nxt;
    logic                    mem_op;
    logic                    bubble;
    logic [DATA_W-1:0]       wb_data_nxt;

    assign mem_op = memRd_IN | memWr_IN;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            memErr     <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            dmem_req   <= req_nxt;
            dmem_we    <= we_nxt;
            dmem_addr  <= addr_nxt;
            dmem_wdata <= wdata_nxt;
            memErr     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        req_nxt      = dmem_req;
        we_nxt       = dmem_we;
        addr_nxt     = dmem_addr;
        wdata_nxt    = dmem_wdata;
        err_nxt      = memErr;
        stall        = 1'b0;
        bubble       = 1'b1;
        wb_data_nxt  = aluRes_IN;

        case (state)
            ST_IDLE: begin
                if (mem_op) begin
                    stall        = 1'b1;
                    state_nxt    = ST_ACCESS;
                    req_nxt      = 1'b1;
                    we_nxt       = memWr_IN;
                    addr_nxt     = aluRes_IN;
                    wdata_nxt    = memWrData_IN;
                    wait_cnt_nxt = '0;
                end else begin
                    bubble = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (dmem_ack) begin
                    state_nxt = ST_IDLE;
                    req_nxt   = 1'b0;
                    bubble    = 1'b0;
                    // Stores write back the ALU result, loads the returned data.
                    wb_data_nxt = dmem_we ? aluRes_IN : dmem_rdata;
                end else if (wait_cnt == WAIT_LAST) begin
                    // Abort: release the pipeline, retire as a bubble, flag it.
                    state_nxt = ST_IDLE;
                    req_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                end else begin
                    stall        = 1'b1;
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    mem_wb_reg #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W)
    ) u_mem_wb (
        .clk       (clk),
        .rst       (rst),
        .bubble    (bubble),
        .reg_wr    (regWr_IN),
        .wb_data   (wb_data_nxt),
        .rd        (rd_IN),
        .reg_wr_q  (regWr_OUT),
        .wb_data_q (wbData_OUT),
        .rd_q      (rd_OUT)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios then randomized traffic, all
// checked against a transaction-level model of the stage.
module tb_mem_stage;

    localparam int DW = 8;
    localparam int RW = 3;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          regWr_IN, memWr_IN, memRd_IN;
    logic [DW-1:0] aluRes_IN, memWrData_IN;
    logic [RW-1:0] rd_IN;
    logic          dmem_req, dmem_we;
    logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic          dmem_ack;
    logic          stall;
    logic          regWr_OUT;
    logic [DW-1:0] wbData_OUT;
    logic [RW-1:0] rd_OUT;
    logic          memErr;

    always #5 clk = ~clk;

    mem_stage #(.DATA_W(DW), .RD_W(RW), .MAX_WAIT(MW)) dut (
        .clk          (clk),
        .rst          (rst),
        .regWr_IN     (regWr_IN),
        .memWr_IN     (memWr_IN),
        .memRd_IN     (memRd_IN),
        .aluRes_IN    (aluRes_IN),
        .memWrData_IN (memWrData_IN),
        .rd_IN        (rd_IN),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .stall        (stall),
        .regWr_OUT    (regWr_OUT),
        .wbData_OUT   (wbData_OUT),
        .rd_OUT       (rd_OUT),
        .memErr       (memErr)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: an access in flight is described by its age in cycles.
    bit          m_known = 1'b0;
    bit          m_pending;
    int          m_age;
    bit          m_req, m_we, m_err, m_regwr;
    int unsigned m_addr, m_wdata, m_wb, m_rd;

    // Observations taken at the latest step.
    bit          o_stall, o_req, o_we, o_regwr, o_err;
    int unsigned o_addr, o_wdata, o_wb, o_rd;

    function automatic bit model_stall();
        if (!m_pending) return memRd_IN | memWr_IN;
        return !dmem_ack && (m_age < MW - 1);
    endfunction

    task automatic model_edge();
        if (!rst) begin
            m_known   = 1'b1;
            m_pending = 1'b0; m_age = 0;
            m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_err = 0;
            m_regwr = 0; m_wb = 0; m_rd = 0;
        end else if (!m_pending) begin
            if (memRd_IN | memWr_IN) begin
                m_pending = 1'b1; m_age = 0;
                m_req = 1; m_we = memWr_IN; m_addr = aluRes_IN; m_wdata = memWrData_IN;
                m_regwr = 0;
            end else begin
                m_regwr = regWr_IN; m_wb = aluRes_IN; m_rd = rd_IN;
            end
        end else if (dmem_ack) begin
            m_pending = 1'b0; m_req = 0;
            m_regwr = regWr_IN; m_rd = rd_IN;
            m_wb = m_we ? aluRes_IN : dmem_rdata;
        end else if (m_age == MW - 1) begin
            m_pending = 1'b0; m_req = 0; m_err = 1; m_regwr = 0;
        end else begin
            m_age++; m_regwr = 0;
        end
    endtask

    task automatic step(input bit r, input bit rw, input bit mw, input bit mr,
                        input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                        input logic [RW-1:0] rdi, input bit ack, input logic [DW-1:0] rdata);
        @(negedge clk);
        rst = r; regWr_IN = rw; memWr_IN = mw; memRd_IN = mr;
        aluRes_IN = alu; memWrData_IN = wd; rd_IN = rdi;
        dmem_ack = ack; dmem_rdata = rdata;
        #1;
        o_stall = stall; o_req = dmem_req; o_we = dmem_we; o_addr = dmem_addr;
        o_wdata = dmem_wdata; o_regwr = regWr_OUT; o_wb = wbData_OUT;
        o_rd = rd_OUT; o_err = memErr;
        if (m_known) begin
            check_eq("stall",      o_stall, model_stall());
            check_eq("dmem_req",   o_req,   m_req);
            check_eq("dmem_we",    o_we,    m_we);
            check_eq("dmem_addr",  o_addr,  m_addr);
            check_eq("dmem_wdata", o_wdata, m_wdata);
            check_eq("regWr_OUT",  o_regwr, m_regwr);
            check_eq("wbData_OUT", o_wb,    m_wb);
            check_eq("rd_OUT",     o_rd,    m_rd);
            check_eq("memErr",     o_err,   m_err);
        end
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle_step(input bit ack);
        step(1, 0, 0, 0, 8'h00, 8'h00, 3'd0, ack, 8'h00);
    endtask

    int n_stall, n_req;

    initial begin
        rst = 1'b0; regWr_IN = 0; memWr_IN = 0; memRd_IN = 0;
        aluRes_IN = 0; memWrData_IN = 0; rd_IN = 0; dmem_ack = 0; dmem_rdata = 0;

        // Reset with random inputs.
        repeat (2) step(0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
                        8'($urandom), 3'($urandom), 1'($urandom), 8'($urandom));
        idle_step(0);
        check_eq("rst_outputs", {o_req, o_we, o_addr[7:0], o_wdata[7:0], o_regwr, o_wb[7:0], o_rd[2:0], o_err}, 0);
        check_eq("rst_stall", o_stall, 0);

        // ALU op.
        step(1, 1, 0, 0, 8'h5A, 8'h00, 3'd3, 0, 8'h00);
        check_eq("alu_stall", o_stall, 0);
        idle_step(0);
        check_eq("alu_wb", {o_regwr, o_wb[7:0], o_rd[2:0]}, {1'b1, 8'h5A, 3'd3});

        // Load with ack after two wait cycles.
        n_stall = 0; n_req = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 1, 8'h10, 8'h00, 3'd5, i == 3, 8'hC3);
            n_stall += int'(o_stall);
            if (o_req) begin
                n_req++;
                check_eq("load_addr", o_addr, 8'h10);
            end
        end
        check_eq("load_stall_cycles", n_stall, 3);
        check_eq("load_req_cycles", n_req, 3);
        idle_step(0);
        check_eq("load_wb", {o_regwr, o_wb[7:0], o_rd[2:0]}, {1'b1, 8'hC3, 3'd5});

        // Store then load, immediate ack.
        step(1, 0, 1, 0, 8'h20, 8'h77, 3'd0, 0, 8'h00);
        step(1, 0, 1, 0, 8'h20, 8'h77, 3'd0, 1, 8'h00);
        check_eq("store_req", {o_req, o_we, o_addr[7:0], o_wdata[7:0]}, {1'b1, 1'b1, 8'h20, 8'h77});
        step(1, 1, 0, 1, 8'h20, 8'h00, 3'd2, 0, 8'h00);
        check_eq("gap_req_low", o_req, 0);
        step(1, 1, 0, 1, 8'h20, 8'h00, 3'd2, 1, 8'h77);
        check_eq("load2_req", {o_req, o_we, o_addr[7:0]}, {1'b1, 1'b0, 8'h20});
        idle_step(0);
        check_eq("load2_wb", {o_regwr, o_wb[7:0], o_rd[2:0]}, {1'b1, 8'h77, 3'd2});

        // Timeout.
        n_stall = 0;
        for (int i = 0; i < MW + 1; i++) begin
            step(1, 1, 0, 1, 8'h44, 8'h00, 3'd6, 0, 8'h00);
            n_stall += int'(o_stall);
        end
        check_eq("timeout_stall_cycles", n_stall, MW);
        idle_step(1);
        check_eq("timeout_err", {o_err, o_regwr, o_req}, {1'b1, 1'b0, 1'b0});
        idle_step(1);
        check_eq("timeout_sticky", {o_err, o_req}, {1'b1, 1'b0});

        // Reset in the second ACCESS cycle.
        step(1, 1, 0, 1, 8'h33, 8'h00, 3'd1, 0, 8'h00);
        step(1, 1, 0, 1, 8'h33, 8'h00, 3'd1, 0, 8'h00);
        step(0, 1, 0, 1, 8'h33, 8'h00, 3'd1, 0, 8'h00);
        check_eq("mid_access_req", o_req, 1);
        idle_step(0);
        check_eq("reset_abandon", {o_req, o_err, o_stall}, 0);

        // Randomized traffic; upstream holds its instruction while stalled.
        begin
            bit rw = 0, mw = 0, mr = 0;
            logic [DW-1:0] alu = '0, wd = '0;
            logic [RW-1:0] rdi = '0;
            for (int i = 0; i < 600; i++) begin
                if (!o_stall) begin
                    rw  = 1'($urandom);
                    mw  = ($urandom_range(0, 3) == 0);
                    mr  = ($urandom_range(0, 2) == 0);
                    alu = 8'($urandom);
                    wd  = 8'($urandom);
                    rdi = 3'($urandom);
                end
                step($urandom_range(0, 99) != 0, rw, mw, mr, alu, wd, rdi,
                     $urandom_range(0, 3) == 0, 8'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
